// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state type and helpers for the LCD pin receiver
package lcd_pkg;

    localparam int LCD_WIDTH  = 160;
    localparam int LCD_HEIGHT = 144;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        WAIT = 2'd1,
        LINE = 2'd2
    } lcd_rx_state_t;

    // Row counter advances on every plain commit but must never wrap back to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/lcd_pin_sync.sv
// rtl/lcd_pin_sync.sv - per-pin synchronizer with history flop and edge detect
//
// Ports:
//   clk, nreset : sampling clock, asynchronous active-low reset
//   pin         : raw asynchronous pin
//   level       : synchronized pin level
//   rise, fall  : single-cycle edge indications derived from level vs. history
module lcd_pin_sync
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;

    always_comb begin
        sync_d[0] = pin;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/lcd_pin_receiver.sv
// rtl/lcd_pin_receiver.sv - panel-side receiver rebuilding pixel coordinates from LCD pins
//
// Ports:
//   clk, nreset          : sampling clock (>= 4x CP), asynchronous active-low reset
//   en                   : receiver enable; low holds the receiver in SEEK
//   cp, cpl, st, s, fr   : pixel clock, line latch, line start, frame sync, frame polarity pins
//   ld[1:0]              : pixel data pins
//   pix_valid/x/y/color  : one strobe per received pixel with its coordinates and value
//   line_done/frame_done : commit pulses
//   err_overrun/short/frame/fr : framing error pulses
module lcd_pin_receiver
    import lcd_pkg::*;
#(
    parameter int WIDTH       = LCD_WIDTH,
    parameter int HEIGHT      = LCD_HEIGHT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       en,
    input  logic       cp,
    input  logic       cpl,
    input  logic       st,
    input  logic       s,
    input  logic       fr,
    input  logic [1:0] ld,
    output logic       pix_valid,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic [1:0] pix_color,
    output logic       line_done,
    output logic       frame_done,
    output logic       err_overrun,
    output logic       err_short,
    output logic       err_frame,
    output logic       err_fr
);

    localparam logic [7:0] W8     = 8'(WIDTH);
    localparam logic [7:0] H8     = 8'(HEIGHT);
    localparam logic [7:0] H_LAST = 8'(HEIGHT - 1);

    // Pin order: 0 cp, 1 cpl, 2 st, 3 s, 4 fr, 5 ld0, 6 ld1.
    logic [6:0] pin_raw;
    logic [6:0] pin_lvl;
    logic [6:0] pin_rise;
    logic [6:0] pin_fall;

    assign pin_raw = {ld, fr, s, st, cpl, cp};

    for (genvar i = 0; i < 7; i++) begin : g_sync
        lcd_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .nreset (nreset),
            .pin    (pin_raw[i]),
            .level  (pin_lvl[i]),
            .rise   (pin_rise[i]),
            .fall   (pin_fall[i])
        );
    end

    logic       cp_fall;
    logic       cpl_rise;
    logic       st_rise;
    logic       s_lvl;
    logic       fr_lvl;
    logic [1:0] ld_lvl;
    logic       unused_pins;

    assign cp_fall     = pin_fall[0];
    assign cpl_rise    = pin_rise[1];
    assign st_rise     = pin_rise[2];
    assign s_lvl       = pin_lvl[3];
    assign fr_lvl      = pin_lvl[4];
    assign ld_lvl      = pin_lvl[6:5];
    assign unused_pins = ^{pin_lvl[2:0], pin_rise[0], pin_rise[6:3], pin_fall[6:1]};

    lcd_rx_state_t state_q, state_d;
    logic [7:0]    col_q, col_d;
    logic [7:0]    row_q, row_d;
    logic          fr_prev_q, fr_prev_d;
    logic          fr_valid_q, fr_valid_d;
    logic          pix_valid_q, pix_valid_d;
    logic [7:0]    pix_x_q, pix_x_d;
    logic [7:0]    pix_y_q, pix_y_d;
    logic [1:0]    pix_color_q, pix_color_d;
    logic          line_done_q, line_done_d;
    logic          frame_done_q, frame_done_d;
    logic          err_overrun_q, err_overrun_d;
    logic          err_short_q, err_short_d;
    logic          err_frame_q, err_frame_d;
    logic          err_fr_q, err_fr_d;

    // Event order within one cycle: a CP fall without ST is counted against the
    // current line before any commit; a commit then sees that column; an ST rise
    // rewinds afterwards, and a CP fall arriving with it lands at x=0.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        fr_prev_d     = fr_prev_q;
        fr_valid_d    = fr_valid_q;
        pix_valid_d   = 1'b0;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_color_d   = pix_color_q;
        line_done_d   = 1'b0;
        frame_done_d  = 1'b0;
        err_overrun_d = 1'b0;
        err_short_d   = 1'b0;
        err_frame_d   = 1'b0;
        err_fr_d      = 1'b0;

        if (!en) begin
            state_d     = SEEK;
            col_d       = '0;
            row_d       = '0;
            fr_prev_d   = 1'b0;
            fr_valid_d  = 1'b0;
            pix_x_d     = '0;
            pix_y_d     = '0;
            pix_color_d = '0;
        end else begin
            case (state_q)
                SEEK: begin
                    if (cpl_rise && s_lvl) begin
                        state_d = WAIT;
                        col_d   = '0;
                        row_d   = 8'd1;
                    end
                end
                WAIT, LINE: begin
                    if (state_q == LINE && cp_fall && !st_rise) begin
                        if (col_d < W8) begin
                            pix_valid_d = 1'b1;
                            pix_x_d     = col_d;
                            pix_y_d     = row_d;
                            pix_color_d = ld_lvl;
                            col_d       = col_d + 8'd1;
                        end else begin
                            err_overrun_d = 1'b1;
                        end
                    end

                    if (cpl_rise) begin
                        state_d     = WAIT;
                        line_done_d = 1'b1;
                        err_short_d = (col_d != W8);
                        if (s_lvl) begin
                            // S-marked commit closes line 0 of a new frame.
                            frame_done_d = (H_LAST == 8'd0);
                            err_frame_d  = (row_q != H8);
                            err_fr_d     = fr_valid_q && (fr_lvl == fr_prev_q);
                            fr_prev_d    = fr_lvl;
                            fr_valid_d   = 1'b1;
                            row_d        = 8'd1;
                        end else begin
                            frame_done_d = (row_q == H_LAST);
                            row_d        = sat_inc8(row_q);
                        end
                    end

                    if (st_rise) begin
                        state_d = LINE;
                        col_d   = '0;
                        if (cp_fall) begin
                            pix_valid_d = 1'b1;
                            pix_x_d     = 8'd0;
                            pix_y_d     = row_d;
                            pix_color_d = ld_lvl;
                            col_d       = 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = SEEK;
                    col_d   = '0;
                    row_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= SEEK;
            col_q         <= '0;
            row_q         <= '0;
            fr_prev_q     <= 1'b0;
            fr_valid_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_color_q   <= '0;
            line_done_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            err_short_q   <= 1'b0;
            err_frame_q   <= 1'b0;
            err_fr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            fr_prev_q     <= fr_prev_d;
            fr_valid_q    <= fr_valid_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_color_q   <= pix_color_d;
            line_done_q   <= line_done_d;
            frame_done_q  <= frame_done_d;
            err_overrun_q <= err_overrun_d;
            err_short_q   <= err_short_d;
            err_frame_q   <= err_frame_d;
            err_fr_q      <= err_fr_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_color   = pix_color_q;
    assign line_done   = line_done_q;
    assign frame_done  = frame_done_q;
    assign err_overrun = err_overrun_q;
    assign err_short   = err_short_q;
    assign err_frame   = err_frame_q;
    assign err_fr      = err_fr_q;

endmodule

// File: tb/tb_lcd_pin_receiver.sv
// tb/tb_lcd_pin_receiver.sv - scoreboard bench for lcd_pin_receiver
module tb_lcd_pin_receiver;

    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic       cp, cpl, st, s, fr;
    logic [1:0] ld;
    logic       pix_valid;
    logic [7:0] pix_x, pix_y;
    logic [1:0] pix_color;
    logic       line_done, frame_done;
    logic       err_overrun, err_short, err_frame, err_fr;

    always #5 clk = ~clk;

    lcd_pin_receiver #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .en          (en),
        .cp          (cp),
        .cpl         (cpl),
        .st          (st),
        .s           (s),
        .fr          (fr),
        .ld          (ld),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .err_overrun (err_overrun),
        .err_short   (err_short),
        .err_frame   (err_frame),
        .err_fr      (err_fr)
    );

    // Monitor: records every strobe and counts pulses.
    logic [17:0] obs_mem [0:1023];
    int          n_pix = 0, n_line = 0, n_frame = 0, n_ovr = 0;
    int          n_short = 0, n_sld = 0, n_ferr = 0, n_frerr = 0;
    logic [7:0]  max_x = 8'd0;

    always @(negedge clk) begin
        if (pix_valid) begin
            if (n_pix < 1024) obs_mem[n_pix] <= {pix_x, pix_y, pix_color};
            n_pix <= n_pix + 1;
            if (pix_x > max_x) max_x <= pix_x;
        end
        if (line_done)   n_line  <= n_line + 1;
        if (frame_done)  n_frame <= n_frame + 1;
        if (err_overrun) n_ovr   <= n_ovr + 1;
        if (err_short)   n_short <= n_short + 1;
        if (err_short && line_done) n_sld <= n_sld + 1;
        if (err_frame)   n_ferr  <= n_ferr + 1;
        if (err_fr)      n_frerr <= n_frerr + 1;
    end

    int          checks = 0;
    int          failures = 0;
    int          rd_i = 0;
    logic [17:0] exp_q [$];
    int          b_pix, b_line, b_frame, b_ovr, b_short, b_sld, b_ferr, b_frerr;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_px(input string tag, input logic [17:0] obs, input logic [17:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s_pixel: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   tag, obs[17:10], obs[9:2], obs[1:0], expv[17:10], expv[9:2], expv[1:0]);
        end
    endtask

    task automatic drain(input string tag);
        logic [17:0] e;
        while (rd_i < n_pix) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL %s_unexpected: observed strobe x=%0d y=%0d expected none",
                       tag, obs_mem[rd_i][17:10], obs_mem[rd_i][9:2]);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_px(tag, obs_mem[rd_i], e);
            end
            rd_i++;
        end
        check({tag, "_missing"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic snap();
        b_pix = n_pix; b_line = n_line; b_frame = n_frame; b_ovr = n_ovr;
        b_short = n_short; b_sld = n_sld; b_ferr = n_ferr; b_frerr = n_frerr;
    endtask

    task automatic cp_pulse(input int x, input int y, input bit exp_px);
        @(negedge clk); cp = 1'b1; ld = 2'(x % 4);
        @(negedge clk);
        @(negedge clk); cp = 1'b0;
        if (exp_px) exp_q.push_back({8'(x), 8'(y), 2'(x % 4)});
        @(negedge clk);
    endtask

    task automatic st_pulse();
        @(negedge clk); st = 1'b1;
        @(negedge clk);
        @(negedge clk); st = 1'b0;
    endtask

    task automatic cpl_pulse(input bit s_v, input bit fr_v);
        @(negedge clk); s = s_v; fr = fr_v;
        @(negedge clk); cpl = 1'b1;
        @(negedge clk);
        @(negedge clk); cpl = 1'b0;
        @(negedge clk); s = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_line(input int n_cp, input int y, input int n_exp, input bit s_v, input bit fr_v);
        st_pulse();
        for (int i = 0; i < n_cp; i++) cp_pulse(i, y, i < n_exp);
        cpl_pulse(s_v, fr_v);
    endtask

    initial begin
        nreset = 1'b0; en = 1'b1;
        cp = 1'b0; cpl = 1'b0; st = 1'b0; s = 1'b0; fr = 1'b0; ld = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_pulses", int'({pix_valid, line_done, frame_done, err_overrun,
                                     err_short, err_frame, err_fr}), 0);
        check("reset_pixel", int'({pix_x, pix_y, pix_color}), 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Lock on in SEEK, then finish the partial frame (rows 1..H-1).
        snap();
        do_line(0, 0, 0, 1'b1, 1'b0);
        check("seek_exit_line_done", n_line - b_line, 0);
        for (int r = 1; r < H; r++) do_line(W, r, W, 1'b0, 1'b0);
        drain("warmup");

        // One complete frame; line 0 pixels carry the stale row H.
        snap();
        do_line(W, H, W, 1'b1, 1'b1);
        for (int r = 1; r < H; r++) do_line(W, r, W, 1'b0, 1'b0);
        check("frame_strobes", n_pix - b_pix, W * H);
        check("frame_line_done", n_line - b_line, H);
        check("frame_done", n_frame - b_frame, 1);
        check("frame_errors", (n_ovr - b_ovr) + (n_short - b_short) + (n_ferr - b_ferr)
                              + (n_frerr - b_frerr), 0);
        check_px("frame_last", obs_mem[n_pix - 1], {8'(W - 1), 8'(H - 1), 2'd3});
        drain("frame");

        // Second frame start with the same fr value.
        snap();
        do_line(W, H, W, 1'b1, 1'b1);
        check("fr_repeat_err_fr", n_frerr - b_frerr, 1);
        check("fr_repeat_err_frame", n_ferr - b_ferr, 0);

        // One CP fall too many.
        snap();
        do_line(W + 1, 1, W, 1'b0, 1'b0);
        check("overrun_count", n_ovr - b_ovr, 1);
        check("overrun_no_short", n_short - b_short, 0);
        check("overrun_max_x", int'(max_x), W - 1);

        // Short line.
        snap();
        do_line(10, 2, 10, 1'b0, 1'b0);
        check("short_count", n_short - b_short, 1);
        check("short_with_line_done", n_sld - b_sld, 1);
        drain("c_lines");

        // ST rise coincident with CP fall.
        snap();
        @(negedge clk); cp = 1'b1; ld = 2'd0;
        @(negedge clk);
        @(negedge clk); st = 1'b1; cp = 1'b0;
        exp_q.push_back({8'd0, 8'd3, 2'd0});
        @(negedge clk);
        @(negedge clk); st = 1'b0;
        for (int i = 1; i < W; i++) cp_pulse(i, 3, 1'b1);
        cpl_pulse(1'b0, 1'b0);
        check("coincide_first_x", int'(obs_mem[b_pix][17:10]), 0);
        check("coincide_second_x", int'(obs_mem[b_pix + 1][17:10]), 1);
        check("coincide_no_short", n_short - b_short, 0);
        drain("coincide");

        // Early S-marked commit.
        snap();
        do_line(W, 4, W, 1'b1, 1'b0);
        check("early_s_err_frame", n_ferr - b_ferr, 1);
        check("early_s_no_err_fr", n_frerr - b_frerr, 0);
        do_line(W, 1, W, 1'b0, 1'b0);
        drain("early_s");

        // Reset mid-line, resume without S.
        st_pulse();
        for (int i = 0; i < 5; i++) cp_pulse(i, 2, 1'b1);
        repeat (4) @(negedge clk);
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        drain("pre_reset");
        snap();
        do_line(W, 0, 0, 1'b0, 1'b0);
        check("resync_no_strobes", n_pix - b_pix, 0);
        do_line(0, 0, 0, 1'b1, 1'b0);
        check("resync_no_line_done", n_line - b_line, 0);

        // Row 1 after resync, with pin-to-strobe latency measured on x=0.
        st_pulse();
        @(negedge clk); cp = 1'b1; ld = 2'd0;
        @(negedge clk);
        @(negedge clk); cp = 1'b0;
        exp_q.push_back({8'd0, 8'd1, 2'd0});
        @(posedge clk); #1;
        check("latency_edge1", int'(pix_valid), 0);
        @(posedge clk); #1;
        check("latency_edge2", int'(pix_valid), 0);
        @(posedge clk); #1;
        check("latency_edge3", int'(pix_valid), 1);
        for (int i = 1; i < W; i++) cp_pulse(i, 1, 1'b1);
        cpl_pulse(1'b0, 1'b0);
        check("resync_line_done", n_line - b_line, 1);
        drain("resync");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
